// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_OP_MULT  = 2'b00,
      MDU_OP_MULTU = 2'b01,
      MDU_OP_DIV   = 2'b10,
      MDU_OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_CALC = 2'b01,
      MDU_FIX  = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             div_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {hi_i, lo_i[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_i};
      if (div_i) begin
         // A clear top bit means the trial subtraction did not go negative.
         if (!diff[WIDTH]) begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional MTHI/MTLO write ports are enabled by defining MDU_HILO_WRITE_EN.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iStart,
   input  logic [1:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iFlush,
`ifdef MDU_HILO_WRITE_EN
   input  logic             iWeHi,
   input  logic             iWeLo,
   input  logic [WIDTH-1:0] iWdata,
`endif
   output logic             oBusy,
   output logic             oDone,
   output logic             oDivZero,
   output logic [WIDTH-1:0] oHi,
   output logic [WIDTH-1:0] oLo
);

   localparam int CNTW = $clog2(WIDTH + 1);

   mdu_state_e       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             divz_q, divz_d;

   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v,
                                               input logic neg);
      return neg ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .div_i  (div_q),
      .hi_i   (acc_hi_q),
      .lo_i   (acc_lo_q),
      .opnd_i (opnd_q),
      .hi_o   (step_hi),
      .lo_o   (step_lo)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= MDU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MDU_IDLE: if (iStart) state_d = MDU_CALC;
         MDU_CALC: begin
            if (iFlush)                    state_d = MDU_IDLE;
            else if (cnt_q == CNTW'(1))    state_d = MDU_FIX;
         end
         MDU_FIX:  state_d = MDU_IDLE;
         default:  state_d = MDU_IDLE;
      endcase
   end

   always_comb begin
      oBusy = (state_q == MDU_CALC) || (state_q == MDU_FIX);
   end

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      dz_d     = dz_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      divz_d   = 1'b0;
      neg_a_d  = neg_a_q;
      mag_a    = mag_of(iA, op_is_signed(iOp) & iA[WIDTH-1]);
      mag_b    = mag_of(iB, op_is_signed(iOp) & iB[WIDTH-1]);
      prod     = neg_if2w({acc_hi_q, acc_lo_q}, neg_a_q ^ neg_b_q);

      unique case (state_q)
         MDU_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
            if (iWeHi) hi_d = iWdata;
            if (iWeLo) lo_d = iWdata;
`endif
            if (iStart) begin
               div_d    = op_is_div(iOp);
               neg_a_d  = op_is_signed(iOp) & iA[WIDTH-1];
               neg_b_d  = op_is_signed(iOp) & iB[WIDTH-1];
               dz_d     = op_is_div(iOp) && (iB == '0);
               acc_hi_d = '0;
               // Divide iterates on the dividend; multiply shifts the multiplier out of LO.
               acc_lo_d = op_is_div(iOp) ? mag_a : mag_b;
               opnd_d   = op_is_div(iOp) ? mag_b : mag_a;
               cnt_d    = CNTW'(WIDTH);
            end
         end
         MDU_CALC: begin
            if (iFlush) begin
               cnt_d = '0;
            end else begin
               acc_hi_d = step_hi;
               acc_lo_d = step_lo;
               cnt_d    = cnt_q - CNTW'(1);
            end
         end
         MDU_FIX: begin
            if (!iFlush) begin
               if (div_q) begin
                  // Remainder follows the dividend sign, which also restores iA on divide-by-zero.
                  hi_d = neg_if(acc_hi_q, neg_a_q);
                  lo_d = dz_q ? '1 : neg_if(acc_lo_q, neg_a_q ^ neg_b_q);
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
               done_d = 1'b1;
               divz_d = dz_q;
            end
         end
         default: ;
      endcase
   end

   function automatic logic [2*WIDTH-1:0] neg_if2w(input logic [2*WIDTH-1:0] v,
                                                   input logic en);
      return en ? -v : v;
   endfunction

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         dz_q     <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         divz_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         dz_q     <= dz_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         divz_q   <= divz_d;
      end
   end

   assign oDone    = done_q;
   assign oDivZero = divz_q;
   assign oHi      = hi_q;
   assign oLo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops, handshake corners, flush and async reset.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         iClk, iRst_n, iStart, iFlush;
   logic [1:0]   iOp;
   logic [W-1:0] iA, iB;
   logic         oBusy, oDone, oDivZero;
   logic [W-1:0] oHi, oLo;
`ifdef MDU_HILO_WRITE_EN
   logic         iWeHi, iWeLo;
   logic [W-1:0] iWdata;
`endif

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           done_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iStart   (iStart),
      .iOp      (iOp),
      .iA       (iA),
      .iB       (iB),
      .iFlush   (iFlush),
`ifdef MDU_HILO_WRITE_EN
      .iWeHi    (iWeHi),
      .iWeLo    (iWeLo),
      .iWdata   (iWdata),
`endif
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oDivZero (oDivZero),
      .oHi      (oHi),
      .oLo      (oLo)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   always @(posedge iClk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Monitor: every oDone pops one expectation.
   always @(negedge iClk) begin
      exp_t e;
      if (oDone) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("hi", oHi, e.hi);
            chk("lo", oLo, e.lo);
            chk("divzero", oDivZero, e.dz);
            chk("latency", cyc, e.done_cyc);
         end
      end
   end

   // Called at a negedge; raises iStart for one cycle and returns at the negedge after accept.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz);
      exp_t e;
      iOp    = op;
      iA     = a;
      iB     = b;
      iStart = 1'b1;
      if (push) begin
         e.hi = ehi; e.lo = elo; e.dz = edz; e.done_cyc = cyc + 1 + W + 1;
         sb_q.push_back(e);
      end
      @(negedge iClk);
      iStart = 1'b0;
   endtask

   task automatic wait_empty();
      int k = 0;
      while (sb_q.size() != 0 && k < 200) begin
         @(negedge iClk);
         k++;
      end
      if (sb_q.size() != 0) begin
         chk("done_timeout", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
      @(negedge iClk);
   endtask

   task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
      @(negedge iClk);
      issue(op, a, b, 1'b1, ehi, elo, edz);
      wait_empty();
   endtask

   initial begin
      int d0;
      int k;
      iRst_n = 1'b0; iStart = 1'b0; iFlush = 1'b0; iOp = 2'b00; iA = '0; iB = '0;
`ifdef MDU_HILO_WRITE_EN
      iWeHi = 1'b0; iWeLo = 1'b0; iWdata = '0;
`endif
      repeat (2) @(negedge iClk);
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oDone, 0);
      chk("rst_divz", oDivZero, 0);
      chk("rst_hi", oHi, 0);
      chk("rst_lo", oLo, 0);
      iRst_n = 1'b1;

      run(MDU_OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      run(MDU_OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      run(MDU_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run(MDU_OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
      run(MDU_OP_DIV,   32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1);
      run(MDU_OP_DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0);
      run(MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);

      // iStart while busy must be dropped.
      d0 = done_cnt;
      @(negedge iClk);
      issue(MDU_OP_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
      repeat (4) @(negedge iClk);
      chk("busy_mid_calc", oBusy, 1);
      iOp = MDU_OP_DIVU; iA = 32'd100; iB = 32'd10; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      wait_empty();
      repeat (40) @(negedge iClk);
      chk("single_done", 64'(done_cnt - d0), 64'd1);

      // Flush at accept+10: no result, HI/LO keep 0/42.
      d0 = done_cnt;
      @(negedge iClk);
      issue(MDU_OP_MULTU, 32'd16, 32'd16, 1'b0, '0, '0, 1'b0);
      repeat (9) @(negedge iClk);
      iFlush = 1'b1;
      @(negedge iClk);
      iFlush = 1'b0;
      chk("flush_busy", oBusy, 0);
      chk("flush_hi", oHi, 32'd0);
      chk("flush_lo", oLo, 32'd42);
      repeat (40) @(negedge iClk);
      chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
      chk("flush_lo_hold", oLo, 32'd42);

      // Back-to-back: start in the oDone cycle.
      @(negedge iClk);
      issue(MDU_OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
      k = 0;
      while (!oDone && k < 60) begin
         @(negedge iClk);
         k++;
      end
      chk("b2b_first_done", oDone, 1);
      issue(MDU_OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      wait_empty();

      // Async reset pulse mid-CALC.
      @(negedge iClk);
      issue(MDU_OP_MULT, 32'd5, 32'd5, 1'b0, '0, '0, 1'b0);
      repeat (5) @(negedge iClk);
      #2 iRst_n = 1'b0;
      #1;
      chk("arst_busy", oBusy, 0);
      chk("arst_done", oDone, 0);
      chk("arst_hi", oHi, 0);
      chk("arst_lo", oLo, 0);
      #1 iRst_n = 1'b1;
      @(negedge iClk);
      chk("arst_idle", oBusy, 0);
      run(MDU_OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit (MDU) that sits beside the combinational ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and holds results in internal HI/LO registers.
- Multiply uses iterative radix-2 shift-add; divide uses restoring shift-subtract; one sign fix-up cycle follows.
- Start/busy/done handshake lets the pipeline stall only on HI/LO reads.

Parameters:
WIDTH, 32, operand width and HI/LO width; legal range is WIDTH >= 4.
CNTW, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
iClk  in  1  clock, rising edge.
iRst_n  in  1  asynchronous active-low reset.
iStart  in  1  request; sampled only in IDLE.
iOp  in  2  operation select, from the package op codes.
iA  in  WIDTH  multiplicand or dividend.
iB  in  WIDTH  multiplier or divisor.
iFlush  in  1  abort the operation in flight.
oBusy  out  1  high in CALC and FIX.
oDone  out  1  one-cycle pulse; HI/LO are valid in that cycle.
oDivZero  out  1  high with oDone when a DIV/DIVU had iB==0.
oHi  out  WIDTH  HI register (product upper half, or remainder).
oLo  out  WIDTH  LO register (product lower half, or quotient).

Behaviour:
- Reset (async, iRst_n=0): state=IDLE, counter=0; oBusy=0, oDone=0, oDivZero=0, oHi=0, oLo=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- Accept: iStart=1 in IDLE at edge E0.
  - Latch the op and the operand magnitudes. Signed ops take two's-complement abs; signs are recorded.
  - Clear the accumulator; counter=WIDTH; go to CALC.
- CALC: one iteration per edge; the counter decrements; leave for FIX when the counter reaches 0. That is WIDTH edges, E1..E_WIDTH.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the 2*WIDTH accumulator right by 1, carry included.
  - Divide: shift {rem, quo} left by 1. Trial-subtract the divisor from the remainder (WIDTH+1 bits). If non-negative, keep the difference and set quo LSB=1.
- FIX at edge E_WIDTH+1:
  - Apply signs. Signed product is negated when the operand signs differ. Quotient is negated when signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Write oHi/oLo, set oDone=1, go to IDLE.
- Total latency: oDone is high in the cycle after E_WIDTH+1, i.e. WIDTH+1 edges after the accept edge.
- oBusy is high from the cycle after E0 through the cycle before oDone.
- oDone and oDivZero fall on the next edge.
- An iStart in the oDone cycle is accepted, giving back-to-back operations with no bubble.
- iStart while oBusy=1 is ignored; no queueing.
- Divide by zero (DIV/DIVU, iB==0):
  - Runs the full latency.
  - Result: oLo = all ones, oHi = dividend (iA as given, signed or not); oDivZero=1 with oDone.
  - Signed fix-up is suppressed for this case.
- Signed overflow: DIV of most-negative by -1 gives oLo = most-negative, oHi = 0, no flag.
- iFlush=1 in CALC or FIX: next state IDLE, oBusy=0, no oDone, HI/LO unchanged. iFlush is ignored in IDLE.
- iFlush and iStart together in IDLE: the start is accepted.
- Reset asserted mid-operation: immediate return to the reset state; the operation is lost.

Optional Feature:
- Macro: MDU_HILO_WRITE_EN.
- Defined:
  - Adds input ports iWeHi (1), iWeLo (1) and iWdata (WIDTH) for MTHI/MTLO.
  - A write takes effect at the next edge, in IDLE only. While busy it is ignored.
  - Same-edge iStart has no conflict, because results are written only in FIX.
- Undefined: the ports are absent; HI/LO are written only by FIX.

Decomposition:
- Shared package mdu_pkg:
  - MDU_OP_MULT=2'b00, MDU_OP_MULTU=2'b01, MDU_OP_DIV=2'b10, MDU_OP_DIVU=2'b11.
  - State encoding MDU_IDLE/MDU_CALC/MDU_FIX.
- One natural sub-module: mdu_step. It is combinational and performs one shift-add or shift-subtract iteration, parametrised by WIDTH.
- The top level holds the FSM, counter, sign bookkeeping and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFF, B=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, oDone exactly 33 edges after accept. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x12345678, B=0 -> oDivZero=1, LO=0xFFFFFFFF, HI=0x12345678. Next op DIVU 9/3 -> oDivZero=0, LO=3, HI=0.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, oDivZero=0.
- Handshake cases:
  - iStart pulsed during CALC -> ignored.
  - iFlush at accept+10 -> oBusy=0 next cycle, no oDone, HI/LO hold previous values.
  - iStart in the oDone cycle -> accepted, second oDone 33 edges later.
- iRst_n low for part of a cycle mid-CALC -> outputs are 0 immediately, state IDLE. A fresh MULTU 3*5 after release -> LO=15, HI=0.
